// File: rtl/pipelined_addsub_pkg.sv
// Shared types and elaboration helpers for the carry-pipelined add/subtract unit.
package pipelined_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultStages = 4;

  // Legal split: at least one slice, no slice narrower than a bit, equal slices.
  function automatic bit slices_ok(input int unsigned width, input int unsigned stages);
    if (stages == 0 || stages > width) begin
      return 1'b0;
    end
    return (width % stages) == 0;
  endfunction

  // Slice width for a legal split; guarded so a bad split still elaborates to its error.
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    if (stages == 0) begin
      return 1;
    end
    return (width / stages == 0) ? 1 : width / stages;
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand-issue and result-consumer handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  import pipelined_addsub_pkg::*;

  // Issue side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  op_e              in_op;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             out_ovf;

  // Issue/consume logic (or a bench) drives operands and accepts results.
  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_co, out_ovf
  );

  // The arithmetic unit.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_co, out_ovf
  );

endinterface

// File: rtl/pipelined_addsub_slice.sv
// Combinational SW-bit adder slice: sum, carry out, and carry into the slice MSB.
module pipelined_addsub_slice #(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_co,
  output logic          o_cmsb
);

  logic [SW:0] w_total;

  // One extra bit catches the carry out of the slice.
  always_comb begin
    w_total = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};
  end

  assign o_sum  = w_total[SW-1:0];
  assign o_co   = w_total[SW];
  // Sum MSB = a ^ b ^ carry-in, so the carry into the MSB falls out of it.
  assign o_cmsb = i_a[SW-1] ^ i_b[SW-1] ^ w_total[SW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-pipelined add/subtract: one SW-bit slice per clock, carry registered between
// slices, valid/ready on both sides and a global stall when the result is not taken.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned STAGES = DefaultStages
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_addsub_if.slave  bus
);

  localparam int unsigned SW = slice_width(WIDTH, STAGES);

  if (!slices_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_addsub: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic             w_out_valid;
  logic             w_advance;

  // Subtract is A + ~B + 1; the caller's carry-in only matters for add.
  always_comb begin
    w_sub     = (bus.in_op == OP_SUB);
    w_b_eff   = w_sub ? ~bus.in_b : bus.in_b;
    w_cin_eff = w_sub ? 1'b1 : bus.in_cin;
  end

  // The whole pipe moves together: it advances unless a held result is refused.
  assign w_advance   = !w_out_valid || bus.out_ready;
  assign bus.in_ready = w_advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned DoneW = (k + 1) * SW;
    localparam int unsigned RemW  = WIDTH - DoneW;

    logic [SW-1:0]    w_a;
    logic [SW-1:0]    w_b;
    logic [SW-1:0]    w_s;
    logic             w_ci;
    logic             w_co;
    logic             w_cm;
    logic             w_vld;
    logic [DoneW-1:0] w_sum_d;

    logic             r_vld;
    logic             r_cy;
    logic [DoneW-1:0] r_sum;

    if (k == 0) begin : g_head
      assign w_a     = bus.in_a[SW-1:0];
      assign w_b     = w_b_eff[SW-1:0];
      assign w_ci    = w_cin_eff;
      assign w_vld   = bus.in_valid;
      assign w_sum_d = w_s;
    end else begin : g_body
      assign w_a     = g_stage[k-1].g_skew.r_a[SW-1:0];
      assign w_b     = g_stage[k-1].g_skew.r_b[SW-1:0];
      assign w_ci    = g_stage[k-1].r_cy;
      assign w_vld   = g_stage[k-1].r_vld;
      // Finished low slices ride along (deskew) under the new slice.
      assign w_sum_d = {w_s, g_stage[k-1].r_sum};
    end

    pipelined_addsub_slice #(
      .SW (SW)
    ) u_slice (
      .i_a    (w_a),
      .i_b    (w_b),
      .i_cin  (w_ci),
      .o_sum  (w_s),
      .o_co   (w_co),
      .o_cmsb (w_cm)
    );

    // Stage k state: valid, inter-slice carry and the low sum bits finished so far.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_sum <= '0;
      end else if (w_advance) begin
        r_vld <= w_vld;
        r_cy  <= w_co;
        r_sum <= w_sum_d;
      end
    end

    // Operand slices not yet consumed travel forward (skew), B already conditioned.
    if (k < STAGES - 1) begin : g_skew
      logic [RemW-1:0] w_a_up;
      logic [RemW-1:0] w_b_up;
      logic [RemW-1:0] r_a;
      logic [RemW-1:0] r_b;

      if (k == 0) begin : g_src_in
        assign w_a_up = bus.in_a[WIDTH-1:SW];
        assign w_b_up = w_b_eff[WIDTH-1:SW];
      end else begin : g_src_skew
        assign w_a_up = g_stage[k-1].g_skew.r_a[SW +: RemW];
        assign w_b_up = g_stage[k-1].g_skew.r_b[SW +: RemW];
      end

      // Upper operand bits wait here until their slice comes up.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_a_up;
          r_b <= w_b_up;
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic r_ovf;

      // Signed overflow: carry into the MSB disagrees with the carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= w_cm ^ w_co;
        end
      end
    end
  end

  assign w_out_valid   = g_stage[STAGES-1].r_vld;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = g_stage[STAGES-1].r_sum;
  assign bus.out_co    = g_stage[STAGES-1].r_cy;
  assign bus.out_ovf   = g_stage[STAGES-1].g_tail.r_ovf;

`ifndef SYNTHESIS
  // A refused result must stay put, bit for bit, until it is taken.
  property p_hold_on_stall;
    @(posedge clk) disable iff (!rst_n)
      (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.out_sum) && $stable(bus.out_co) &&
         $stable(bus.out_ovf));
  endproperty
  a_hold_on_stall: assert property (p_hold_on_stall);

  // Operands are only taken when the pipe can move.
  a_ready_is_advance: assert property (@(posedge clk) disable iff (!rst_n)
    bus.in_ready == (!bus.out_valid || bus.out_ready));
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=16, STAGES=4) with hand-computed results.
module tb_pipelined_addsub;
  import pipelined_addsub_pkg::*;

  localparam int unsigned Width  = 16;
  localparam int unsigned Stages = 4;
  localparam int          NVec   = 16;

  logic clk;
  logic rst_n;
  int   cyc;

  int n_checks;
  int n_pass;

  pipelined_addsub_if #(.WIDTH(Width)) bus_if ();

  pipelined_addsub #(
    .WIDTH  (Width),
    .STAGES (Stages)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Hand-computed vectors: a, b, cin, op -> sum, co, ovf
  logic [15:0] va   [NVec] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234,
                               16'h1234, 16'h8000, 16'h0F0F, 16'h0000, 16'hFFFF, 16'h7FFF,
                               16'h00FF, 16'hABCD, 16'h4000, 16'hFFFF};
  logic [15:0] vb   [NVec] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h4321,
                               16'h1234, 16'h8000, 16'h00F1, 16'h0001, 16'hFFFF, 16'hFFFF,
                               16'h0001, 16'h1234, 16'h4000, 16'h8000};
  logic        vcin [NVec] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  op_e         vop  [NVec] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_SUB, OP_ADD,
                               OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD, OP_SUB};
  logic [15:0] es   [NVec] = '{16'h0100, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h5556,
                               16'h0000, 16'h0000, 16'h1001, 16'hFFFF, 16'hFFFF, 16'h8000,
                               16'h0101, 16'h9999, 16'h8000, 16'h7FFF};
  logic        eco  [NVec] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        eovf [NVec] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  int exp_q  [$];
  int acc_q  [$];
  int xfer_q [$];
  bit chk_lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present vector idx from posedge+1 until accepted; leaves at posedge+1 with in_valid low.
  task automatic issue(input int idx);
    bit accepted;
    accepted        = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = va[idx];
    bus_if.in_b     = vb[idx];
    bus_if.in_cin   = vcin[idx];
    bus_if.in_op    = vop[idx];
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        accepted = 1'b1;
        exp_q.push_back(idx);
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check($sformatf("accept_timeout[%0d]", idx), 32'd0, 32'd1);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // Scoreboard: every transfer must be the next expected vector, in order.
  always @(negedge clk) begin : mon
    int idx;
    int ac;
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'd1, 32'd0);
      end else begin
        idx = exp_q.pop_front();
        ac  = acc_q.pop_front();
        check($sformatf("sum[%0d]", idx), bus_if.out_sum, es[idx]);
        check($sformatf("co[%0d]", idx), bus_if.out_co, eco[idx]);
        check($sformatf("ovf[%0d]", idx), bus_if.out_ovf, eovf[idx]);
        if (chk_lat) check($sformatf("latency[%0d]", idx), cyc - ac, Stages);
        xfer_q.push_back(cyc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    n_checks         = 0;
    n_pass           = 0;
    cyc              = 0;
    chk_lat          = 1'b1;
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = '0;
    bus_if.in_b      = '0;
    bus_if.in_cin    = 1'b0;
    bus_if.in_op     = OP_ADD;
    bus_if.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_out_sum", bus_if.out_sum, 0);
    check("rst_out_co", bus_if.out_co, 0);
    check("rst_out_ovf", bus_if.out_ovf, 0);
    check("rst_in_ready", bus_if.in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus_if.in_ready, 1);
    check("post_rst_out_valid", bus_if.out_valid, 0);
    @(posedge clk);
    #1;

    // Single operations: carry, overflow and borrow corner cases, latency checked
    for (int i = 0; i < 5; i++) begin
      issue(i);
      drain();
    end

    // Eight back-to-back ops: results on eight consecutive cycles
    xfer_q.delete();
    for (int i = 0; i < 8; i++) issue(i);
    drain();
    check("b2b_count", xfer_q.size(), 8);
    for (int i = 1; i < 8 && i < xfer_q.size(); i++) begin
      check($sformatf("b2b_gap[%0d]", i), xfer_q[i] - xfer_q[i-1], 1);
    end

    // Stall with a full pipe: outputs frozen, no input taken, nothing lost on release
    chk_lat          = 1'b0;
    bus_if.out_ready = 1'b0;
    for (int i = 8; i < 12; i++) issue(i);
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = va[12];
    bus_if.in_b     = vb[12];
    bus_if.in_cin   = vcin[12];
    bus_if.in_op    = vop[12];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_valid", bus_if.out_valid, 1);
      check("stall_in_ready", bus_if.in_ready, 0);
      check("stall_sum", bus_if.out_sum, es[8]);
      check("stall_co", bus_if.out_co, eco[8]);
      check("stall_ovf", bus_if.out_ovf, eovf[8]);
      @(posedge clk);
      #1;
    end
    bus_if.out_ready = 1'b1;
    issue(12);
    drain();

    // Async reset with three ops in flight and one at the output
    chk_lat = 1'b1;
    issue(13);
    issue(14);
    issue(15);
    issue(0);
    issue(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus_if.out_valid, 0);
    check("midrst_out_sum", bus_if.out_sum, 0);
    check("midrst_out_co", bus_if.out_co, 0);
    check("midrst_out_ovf", bus_if.out_ovf, 0);
    check("midrst_in_ready", bus_if.in_ready, 1);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_midrst_idle", bus_if.out_valid, 0);
      @(posedge clk);
      #1;
    end
    issue(5);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
